// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the phase-4 CPU.
// It fetches an instruction, decodes the IR opcode, and walks T3..T7 to drive every datapath strobe.
// All strobes are decoded from the registered state and the latched opcode, so each strobe holds for a full cycle.
// The one exception is the branch PCin/RZoutLo in T6, which is also qualified by con_ff.
// Optional feature: define ILLEGAL_TRAP_EN to trap undefined opcodes into HALT with illegal=1.
// Without it, undefined opcodes behave as nop and illegal is tied low.
//
// Memory handshake: MDRread (T1, ld T6) and RAMwrite (st T7) act as a request that
// stays asserted, with the FSM parked in that state, until mem_ready is sampled high
// on a rising clock edge. That edge completes the access. mem_ready is ignored in every
// other state.
module control_unit #(
  parameter int IR_W  = 32,
  parameter int ALU_W = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [IR_W-1:0]  ir,
  input  logic             con_ff,
  input  logic             mem_ready,
  input  logic             stop,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             MDRread,
  output logic             RAMwrite,
  output logic             IRin,
  output logic             RYin,
  output logic             RZinLo,
  output logic             RZoutLo,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             RCout,
  output logic             CONin,
  output logic             InPortOut,
  output logic             OutPortIn,
  output logic [ALU_W-1:0] alu_op,
  output logic             run,
  output logic             illegal,
  output logic [3:0]       o_state
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(4);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_op;
  logic [4:0] w_opcode;
  logic       w_legal;
  logic       w_boundary;
  logic       w_is_alu;
  logic       w_unused_ir;

  assign w_opcode    = ir[IR_W-1 -: 5];
  assign w_unused_ir = &{1'b0, ir[IR_W-6:0]};
  assign o_state     = r_state;
  assign w_is_alu    = (r_op == OP_ADD) || (r_op == OP_SUB) ||
                       (r_op == OP_AND) || (r_op == OP_OR);

  // Classify the opcode currently in IR as defined or undefined.
  always_comb begin
    w_legal = 1'b0;
    case (w_opcode)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_BR, OP_IN, OP_OUT, OP_NOP, OP_HALT: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_RESET;
    else        r_state <= w_next;
  end

  // Latch the opcode when leaving T2 so that the execute states do not depend on later IR changes.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)                r_op <= 5'd0;
    else if (r_state == S_T2)  r_op <= w_opcode;
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  // Sticky trap flag: it is set when an undefined opcode is decoded and is released only by clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)                               r_illegal <= 1'b0;
    else if ((r_state == S_T2) && !w_legal)   r_illegal <= 1'b1;
  end
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  // Next-state logic: sequencing, memory stalls, and the instruction-boundary decision on stop.
  always_comb begin
    w_next     = r_state;
    w_boundary = 1'b0;
    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    if (mem_ready) w_next = S_T2;
      S_T2: begin
        if (w_opcode == OP_HALT) begin
          w_next = S_HALT;
        end else if (!w_legal) begin
`ifdef ILLEGAL_TRAP_EN
          w_next = S_HALT;
`else
          w_boundary = 1'b1;
`endif
        end else if (w_opcode == OP_NOP) begin
          w_boundary = 1'b1;
        end else begin
          w_next = S_T3;
        end
      end
      S_T3: begin
        if ((r_op == OP_IN) || (r_op == OP_OUT)) w_boundary = 1'b1;
        else                                     w_next = S_T4;
      end
      S_T4: w_next = S_T5;
      S_T5: begin
        if (w_is_alu || (r_op == OP_ADDI) || (r_op == OP_LDI)) w_boundary = 1'b1;
        else                                                   w_next = S_T6;
      end
      S_T6: begin
        if (r_op == OP_LD) begin
          if (mem_ready) w_next = S_T7;
        end else if (r_op == OP_ST) begin
          w_next = S_T7;
        end else begin
          w_boundary = 1'b1;
        end
      end
      S_T7: begin
        if (r_op == OP_ST) begin
          if (mem_ready) w_boundary = 1'b1;
        end else begin
          w_boundary = 1'b1;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RESET;
    endcase
    if (w_boundary) w_next = stop ? S_HALT : S_T0;
  end

  // Moore output decode: strobes come from the state and the latched opcode.
  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; MDRread = 1'b0; RAMwrite = 1'b0; IRin = 1'b0; RYin = 1'b0;
    RZinLo = 1'b0; RZoutLo = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; RCout = 1'b0; CONin = 1'b0;
    InPortOut = 1'b0; OutPortIn = 1'b0; alu_op = '0;
    run = (r_state != S_RESET) && (r_state != S_HALT);
    case (r_state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1: begin MDRread = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (w_is_alu || (r_op == OP_ADDI)) begin
          Grb = 1'b1; Rout = 1'b1; RYin = 1'b1;
        end else if ((r_op == OP_LDI) || (r_op == OP_LD) || (r_op == OP_ST)) begin
          Grb = 1'b1; BAout = 1'b1; RYin = 1'b1;
        end else if (r_op == OP_BR) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else if (r_op == OP_IN) begin
          InPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (r_op == OP_OUT) begin
          Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1;
        end
      end
      S_T4: begin
        if (w_is_alu) begin
          Grc = 1'b1; Rout = 1'b1; RZinLo = 1'b1;
          case (r_op)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_OR;
          endcase
        end else if (r_op == OP_BR) begin
          PCout = 1'b1; RYin = 1'b1;
        end else begin
          RCout = 1'b1; RZinLo = 1'b1; alu_op = ALU_ADD;
        end
      end
      S_T5: begin
        if ((r_op == OP_LD) || (r_op == OP_ST)) begin
          RZoutLo = 1'b1; MARin = 1'b1;
        end else if (r_op == OP_BR) begin
          RCout = 1'b1; RZinLo = 1'b1; alu_op = ALU_ADD;
        end else begin
          RZoutLo = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T6: begin
        if (r_op == OP_LD) begin
          MDRread = 1'b1; MDRin = 1'b1;
        end else if (r_op == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else begin
          RZoutLo = con_ff; PCin = con_ff;
        end
      end
      S_T7: begin
        if (r_op == OP_LD) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else begin
          RAMwrite = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction streams for control_unit, scored against a per-instruction step model.
module tb_control_unit;
  localparam int W = 28;

  // Observed vector layout: 22 strobes, alu_op[3:0], run, illegal.
  localparam logic [W-1:0] PCOUT   = W'(1) << 27;
  localparam logic [W-1:0] PCIN    = W'(1) << 26;
  localparam logic [W-1:0] INCPC   = W'(1) << 25;
  localparam logic [W-1:0] MARIN   = W'(1) << 24;
  localparam logic [W-1:0] MDRIN   = W'(1) << 23;
  localparam logic [W-1:0] MDROUT  = W'(1) << 22;
  localparam logic [W-1:0] MDRREAD = W'(1) << 21;
  localparam logic [W-1:0] RAMWR   = W'(1) << 20;
  localparam logic [W-1:0] IRIN    = W'(1) << 19;
  localparam logic [W-1:0] RYIN    = W'(1) << 18;
  localparam logic [W-1:0] RZINLO  = W'(1) << 17;
  localparam logic [W-1:0] RZOUTLO = W'(1) << 16;
  localparam logic [W-1:0] GRA     = W'(1) << 15;
  localparam logic [W-1:0] GRB     = W'(1) << 14;
  localparam logic [W-1:0] GRC     = W'(1) << 13;
  localparam logic [W-1:0] RIN     = W'(1) << 12;
  localparam logic [W-1:0] ROUT    = W'(1) << 11;
  localparam logic [W-1:0] BAOUT   = W'(1) << 10;
  localparam logic [W-1:0] RCOUT   = W'(1) << 9;
  localparam logic [W-1:0] CONIN   = W'(1) << 8;
  localparam logic [W-1:0] INPOUT  = W'(1) << 7;
  localparam logic [W-1:0] OUTPIN  = W'(1) << 6;
  localparam logic [W-1:0] A_ADD   = W'(1) << 2;
  localparam logic [W-1:0] A_SUB   = W'(2) << 2;
  localparam logic [W-1:0] A_AND   = W'(3) << 2;
  localparam logic [W-1:0] A_OR    = W'(4) << 2;
  localparam logic [W-1:0] RUN     = W'(2);
  localparam logic [W-1:0] ILL     = W'(1);

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic        mr;
    logic        cf;
    logic        st;
    logic [31:0] ir;
  } drv_t;

  // Clock and reset.
  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] ir = '0;
  logic con_ff = 1'b0, mem_ready = 1'b0, stop = 1'b0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, RAMwrite, IRin, RYin;
  logic RZinLo, RZoutLo, Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin;
  logic InPortOut, OutPortIn, run, illegal;
  logic [3:0] alu_op;
  logic [3:0] o_state;
  logic [W-1:0] obs;

  assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, RAMwrite, IRin, RYin,
                RZinLo, RZoutLo, Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin,
                InPortOut, OutPortIn, alu_op, run, illegal};

  control_unit #(.IR_W(32), .ALU_W(4)) dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .MDRread(MDRread), .RAMwrite(RAMwrite), .IRin(IRin), .RYin(RYin), .RZinLo(RZinLo),
    .RZoutLo(RZoutLo), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .RCout(RCout), .CONin(CONin), .InPortOut(InPortOut), .OutPortIn(OutPortIn),
    .alu_op(alu_op), .run(run), .illegal(illegal), .o_state(o_state)
  );

  // Scoreboard: one entry per expected clock cycle.
  logic [W-1:0] exp_q[$];
  drv_t         drv_q[$];
  string        tag_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One model step. A memory step repeats for `waits` stall cycles before mem_ready rises.
  // Only the final cycle of the last step is an instruction boundary, where stop takes effect.
  task automatic push_step(input logic [W-1:0] m, input bit mem, input int waits_in, input bit last,
                           input bit stop_end, input logic [31:0] irv, input bit cf, input string tag);
    int   waits;
    drv_t d;
    waits = !mem ? 0 : (waits_in >= 0 ? waits_in : int'($urandom_range(0, 3)));
    for (int i = 0; i <= waits; i++) begin
      d.ir = irv;
      d.cf = cf;
      d.mr = mem ? (i == waits) : 1'($urandom_range(0, 1));
      d.st = (last && i == waits) ? stop_end : 1'($urandom_range(0, 1));
      exp_q.push_back(m | RUN);
      drv_q.push_back(d);
      tag_q.push_back($sformatf("%s/%s", tag, (i < waits) ? "stall" : "step"));
    end
  endtask

  // Apply the queued stimulus cycle by cycle, and sample just after the falling edge.
  task automatic drain();
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      drv_t d;
      string t;
      e = exp_q.pop_front();
      d = drv_q.pop_front();
      t = tag_q.pop_front();
      @(negedge clock);
      mem_ready = d.mr; con_ff = d.cf; stop = d.st; ir = d.ir;
      #1;
      check(t, obs, e);
    end
  endtask

  function automatic bit is_legal(input logic [4:0] op);
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd18, 5'd22, 5'd23, 5'd26, 5'd27: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Behavioural model: the cycle-by-cycle strobe list of one instruction, built from the opcode's step table.
  task automatic run_instr(input logic [31:0] irv, input bit cf_in, input bit stop_end,
                           input int mem_waits, input string name);
    logic [4:0] op;
    bit cf, nop_like;
    int fw;
    op = irv[31:27];
    cf = (op == 5'd18) ? cf_in : 1'($urandom_range(0, 1));
    nop_like = (op == 5'd26) || (!is_legal(op) && !TRAP);
    fw = (mem_waits >= 0) ? 0 : -1;
    push_step(PCOUT | MARIN | INCPC, 0, 0, 0, 0, irv, cf, {name, ".T0"});
    push_step(MDRREAD | MDRIN, 1, fw, 0, 0, irv, cf, {name, ".T1"});
    push_step(MDROUT | IRIN, 0, 0, nop_like, stop_end, irv, cf, {name, ".T2"});
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        push_step(GRB | ROUT | RYIN, 0, 0, 0, 0, irv, cf, {name, ".T3"});
        push_step(GRC | ROUT | RZINLO | (op == 5'd3 ? A_ADD : op == 5'd4 ? A_SUB : op == 5'd5 ? A_AND : A_OR),
                  0, 0, 0, 0, irv, cf, {name, ".T4"});
        push_step(RZOUTLO | GRA | RIN, 0, 0, 1, stop_end, irv, cf, {name, ".T5"});
      end
      5'd12: begin
        push_step(GRB | ROUT | RYIN, 0, 0, 0, 0, irv, cf, {name, ".T3"});
        push_step(RCOUT | RZINLO | A_ADD, 0, 0, 0, 0, irv, cf, {name, ".T4"});
        push_step(RZOUTLO | GRA | RIN, 0, 0, 1, stop_end, irv, cf, {name, ".T5"});
      end
      5'd0, 5'd1, 5'd2: begin
        push_step(GRB | BAOUT | RYIN, 0, 0, 0, 0, irv, cf, {name, ".T3"});
        push_step(RCOUT | RZINLO | A_ADD, 0, 0, 0, 0, irv, cf, {name, ".T4"});
        if (op == 5'd1) begin
          push_step(RZOUTLO | GRA | RIN, 0, 0, 1, stop_end, irv, cf, {name, ".T5"});
        end else if (op == 5'd0) begin
          push_step(RZOUTLO | MARIN, 0, 0, 0, 0, irv, cf, {name, ".T5"});
          push_step(MDRREAD | MDRIN, 1, mem_waits, 0, 0, irv, cf, {name, ".T6"});
          push_step(MDROUT | GRA | RIN, 0, 0, 1, stop_end, irv, cf, {name, ".T7"});
        end else begin
          push_step(RZOUTLO | MARIN, 0, 0, 0, 0, irv, cf, {name, ".T5"});
          push_step(GRA | ROUT | MDRIN, 0, 0, 0, 0, irv, cf, {name, ".T6"});
          push_step(RAMWR, 1, mem_waits, 1, stop_end, irv, cf, {name, ".T7"});
        end
      end
      5'd18: begin
        push_step(GRA | ROUT | CONIN, 0, 0, 0, 0, irv, cf, {name, ".T3"});
        push_step(PCOUT | RYIN, 0, 0, 0, 0, irv, cf, {name, ".T4"});
        push_step(RCOUT | RZINLO | A_ADD, 0, 0, 0, 0, irv, cf, {name, ".T5"});
        push_step(cf ? (RZOUTLO | PCIN) : '0, 0, 0, 1, stop_end, irv, cf, {name, ".T6"});
      end
      5'd22: push_step(INPOUT | GRA | RIN, 0, 0, 1, stop_end, irv, cf, {name, ".T3"});
      5'd23: push_step(GRA | ROUT | OUTPIN, 0, 0, 1, stop_end, irv, cf, {name, ".T3"});
      default: ;
    endcase
    drain();
  endtask

  task automatic check_halt(input int n, input bit ill, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      mem_ready = 1'($urandom_range(0, 1)); stop = 1'($urandom_range(0, 1));
      con_ff = 1'($urandom_range(0, 1)); ir = $urandom;
      #1;
      check(tag, obs, ill ? ILL : '0);
    end
  endtask

  // The clear pulse is released mid-cycle, so the following rising edge enters T0.
  task automatic clear_pulse();
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("clear_async", obs, '0);
    #1;
    clear = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] legal_ops[12];
    logic [4:0] ill_ops[5];
    logic [4:0] op;
    bit se, ill;
    legal_ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd18, 5'd22, 5'd23, 5'd26};
    ill_ops   = '{5'd7, 5'd9, 5'd13, 5'd20, 5'd31};

    // Reset state, then an asynchronous clear in the middle of a stalled T1.
    repeat (3) @(negedge clock);
    #1 check("reset", obs, '0);
    clear = 1'b1;
    @(negedge clock); mem_ready = 1'b0;
    #1 check("first_T0", obs, RUN | PCOUT | MARIN | INCPC);
    @(negedge clock);
    #1 check("T1_read", obs, RUN | MDRREAD | MDRIN);
    #2 clear = 1'b0;
    #1 check("clear_mid_T1", obs, '0);
    @(negedge clock);
    #1 check("held_reset", obs, '0);
    clear = 1'b1;

    // Directed instructions.
    run_instr(32'h19890000, 1'b0, 1'b0, -1, "add_r3_r1_r2");
    run_instr({5'd0, 27'h0123456}, 1'b0, 1'b0, 3, "ld_stall3");
    run_instr({5'd2, 27'h0000042}, 1'b0, 1'b0, 2, "st_stall2");
    run_instr({5'd18, 27'h0000010}, 1'b0, 1'b0, -1, "br_cf0");
    run_instr({5'd18, 27'h0000010}, 1'b1, 1'b0, -1, "br_cf1");
    run_instr({5'd26, 27'h0}, 1'b0, 1'b0, -1, "nop");

    run_instr({5'd27, 27'h0}, 1'b0, 1'b0, -1, "halt");
    check_halt(20, 1'b0, "halt_hold");
    clear_pulse();

    run_instr({5'd4, 27'h0ABCDEF}, 1'b0, 1'b1, -1, "sub_stop");
    check_halt(5, 1'b0, "stop_halt");
    clear_pulse();

    run_instr({5'd31, 27'h0}, 1'b0, 1'b0, -1, "opcode_11111");
    if (TRAP) begin
      check_halt(5, 1'b1, "illegal_trap");
      clear_pulse();
    end

    // Random instruction stream with random stalls, stop requests, and occasional undefined opcodes.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) op = ill_ops[$urandom_range(0, 4)];
      else                           op = legal_ops[$urandom_range(0, 11)];
      se  = ($urandom_range(0, 7) == 0);
      ill = TRAP && !is_legal(op);
      run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), se, -1, $sformatf("rnd%0d_op%0d", n, op));
      if (se || ill) begin
        check_halt(3, ill, "rnd_halt");
        clear_pulse();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
